// File: rtl/reg_bus_pkg.sv
//==============================================================================
// Module      : reg_bus_pkg
// Description : Shared types and constants for the register-bus initiator:
//               FSM state encoding, default bus widths, read-latency limit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package reg_bus_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Default bus widths
    localparam int DEFAULT_ADDR_WIDTH  = 32;
    localparam int DEFAULT_WDATA_WIDTH = 32;
    localparam int DEFAULT_RDATA_WIDTH = 32;
    localparam int DEFAULT_CNT_WIDTH   = 16;

    // Read latency limit; the latency counter only needs to hold 0..14
    localparam int MAX_READ_LATENCY = 15;
    localparam int LAT_CNT_WIDTH    = 4;

endpackage : reg_bus_pkg

`default_nettype wire

// File: rtl/reg_bus_initiator.sv
//==============================================================================
// Module      : reg_bus_initiator
// Description : Initiator for the simple register bus. Takes one command at a
//               time on a valid/ready port, drives a single write strobe or a
//               READ_LATENCY-cycle read strobe, and returns one response per
//               command. Every output comes straight from a flop.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_bus_initiator
    import reg_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int WDATA_WIDTH  = DEFAULT_WDATA_WIDTH,
    parameter int RDATA_WIDTH  = DEFAULT_RDATA_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    // Command port
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [WDATA_WIDTH-1:0] cmd_wdata,
    // Response port
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [RDATA_WIDTH-1:0] rsp_rdata,
    // Register bus
    output logic [ADDR_WIDTH-1:0]  address,
    output logic                   write_enable,
    output logic [WDATA_WIDTH-1:0] write_data,
    output logic                   read_enable,
    input  logic [RDATA_WIDTH-1:0] read_data,
    // Status
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   txn_count
);

    // Reject an unsupported read latency at elaboration time
    if ((READ_LATENCY < 1) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_read_latency
        $error("reg_bus_initiator: READ_LATENCY must be in 1..15");
    end

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD = LAT_CNT_WIDTH'(READ_LATENCY - 1);

    state_e                   state_q;
    logic [LAT_CNT_WIDTH-1:0] lat_cnt_q;

    // Latched command; write data is latched straight into the bus register
    // since it is only needed for the single WRITE cycle
    logic                     cmd_write_q;
    logic [ADDR_WIDTH-1:0]    cmd_addr_q;

    // Registered outputs
    logic                     cmd_ready_q;
    logic                     rsp_valid_q;
    logic                     rsp_write_q;
    logic [RDATA_WIDTH-1:0]   rsp_rdata_q;
    logic [ADDR_WIDTH-1:0]    address_q;
    logic                     write_enable_q;
    logic [WDATA_WIDTH-1:0]   write_data_q;
    logic                     read_enable_q;
    logic                     busy_q;
    logic [CNT_WIDTH-1:0]     txn_count_q;
    logic [CNT_WIDTH-1:0]     txn_count_d;

    // Completed-transaction count advances by one and wraps at all-ones
    always_comb begin
        txn_count_d = txn_count_q + 1'b1;
    end

    // Command sequencing FSM with all outputs registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            lat_cnt_q      <= '0;
            cmd_write_q    <= 1'b0;
            cmd_addr_q     <= '0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_write_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            address_q      <= '0;
            write_enable_q <= 1'b0;
            write_data_q   <= '0;
            read_enable_q  <= 1'b0;
            busy_q         <= 1'b0;
            txn_count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_write_q <= cmd_write;
                        cmd_addr_q  <= cmd_addr;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        address_q   <= cmd_addr;
                        if (cmd_write) begin
                            state_q        <= ST_WRITE;
                            write_enable_q <= 1'b1;
                            write_data_q   <= cmd_wdata;
                        end else begin
                            state_q       <= ST_READ;
                            read_enable_q <= 1'b1;
                            lat_cnt_q     <= LAT_LOAD;
                        end
                    end
                end

                ST_WRITE: begin
                    // Single strobe cycle, then return the bus to idle
                    write_enable_q <= 1'b0;
                    write_data_q   <= '0;
                    address_q      <= '0;
                    rsp_valid_q    <= 1'b1;
                    rsp_write_q    <= cmd_write_q;
                    rsp_rdata_q    <= '0;
                    state_q        <= ST_RESP;
                end

                ST_READ: begin
                    if (lat_cnt_q == '0) begin
                        // Last strobe cycle: sample the target's data
                        read_enable_q <= 1'b0;
                        address_q     <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_write_q   <= cmd_write_q;
                        rsp_rdata_q   <= read_data;
                        state_q       <= ST_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                        address_q <= cmd_addr_q;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        txn_count_q <= txn_count_d;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_write    = rsp_write_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign address      = address_q;
    assign write_enable = write_enable_q;
    assign write_data   = write_data_q;
    assign read_enable  = read_enable_q;
    assign busy         = busy_q;
    assign txn_count    = txn_count_q;

endmodule : reg_bus_initiator

`default_nettype wire
